// File: rtl/ifu_fetch_q_if.sv
// Bus between the fetch queue, the instruction SRAM and the decode stage.
// master: the fetch queue itself; slave: the SRAM/pipeline environment.
interface ifu_fetch_q_if;
    logic [15:0] ins_a;     // SRAM byte address, word aligned
    logic        ins_e;     // SRAM read enable
    logic [31:0] ins;       // SRAM read data, one cycle after the enabling edge
    logic        redir_e;   // redirect pulse from the pipeline
    logic [15:0] redir_pc;  // redirect target
    logic        ifu_vld;   // buffer head valid
    logic        ifu_rdy;   // consumer accepts head
    logic [15:0] ifu_pc;    // PC of buffer head
    logic [31:0] ifu_ins;   // instruction word of buffer head

    modport master (
        output ins_a, ins_e, ifu_vld, ifu_pc, ifu_ins,
        input  ins, redir_e, redir_pc, ifu_rdy
    );

    modport slave (
        input  ins_a, ins_e, ifu_vld, ifu_pc, ifu_ins,
        output ins, redir_e, redir_pc, ifu_rdy
    );
endinterface

// File: rtl/ifu_fetch_q.sv
// Instruction fetch queue: issues sequential SRAM reads, buffers the returned
// {pc, ins} pairs in a small FIFO, and flushes on pipeline redirects.
// One read may be outstanding; the SRAM returns data the cycle after issue.
module ifu_fetch_q #(
    parameter logic [15:0] RST_PC = 16'h0000,
    parameter int unsigned DEPTH  = 2
) (
    input logic           clk,
    input logic           rstn,
    ifu_fetch_q_if.master bus
);

    localparam int unsigned   PW   = (DEPTH > 2) ? 2 : 1;
    localparam int unsigned   CW   = 3;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [15:0]   RST_PC_A = RST_PC & 16'hFFFC;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   infl_pc_q, infl_pc_d;
    logic          inflight_q, inflight_d;

    logic          vld;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] occ;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode: redirect masks the head, drops the returning word and blocks issue.
    always_comb begin
        vld   = (count_q != '0) && !bus.redir_e;
        pop   = vld && bus.ifu_rdy;
        push  = inflight_q && !bus.redir_e;
        // pop implies count_q >= 1, so this never underflows
        occ   = count_q + CW'(inflight_q) - CW'(pop);
        issue = !rstn && !bus.redir_e && (occ < CW'(DEPTH));
    end

    assign bus.ins_a   = pc_q;
    assign bus.ins_e   = issue;
    assign bus.ifu_vld = vld;
    assign bus.ifu_pc  = vld ? mem_q[rd_ptr_q].pc  : 16'h0000;
    assign bus.ifu_ins = vld ? mem_q[rd_ptr_q].ins : 32'h00000000;

    // Next-state logic for fetch PC, in-flight tracker and FIFO pointers.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        pc_d       = pc_q;
        infl_pc_d  = infl_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.redir_e) begin
            pc_d     = bus.redir_pc & 16'hFFFC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d      = pc_q + 16'd4;
                infl_pc_d = pc_q;
            end
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state; rstn is active-high and asynchronous.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            pc_q       <= RST_PC_A;
            infl_pc_q  <= 16'h0000;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pc_q       <= pc_d;
            infl_pc_q  <= infl_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: capture the returning word at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count_q alone decides which entries are live.
        if (push) mem_q[wr_ptr_q] <= {infl_pc_q, bus.ins};
    end

endmodule

// File: tb/tb_ifu_fetch_q.sv
// Scoreboard bench for ifu_fetch_q: dut0 uses defaults, dut1 uses
// RST_PC=16'hFFF8 and DEPTH=3. Each has an SRAM model returning
// word n = 32'h13 + n*32'h100 and a monitor that pops its expected queue.
module tb_ifu_fetch_q;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic clk = 1'b0;
    logic rstn0;
    logic rstn1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    ifu_fetch_q_if if0 ();
    ifu_fetch_q_if if1 ();

    ifu_fetch_q dut0 (
        .clk (clk),
        .rstn(rstn0),
        .bus (if0)
    );

    ifu_fetch_q #(
        .RST_PC(16'hFFF8),
        .DEPTH (3)
    ) dut1 (
        .clk (clk),
        .rstn(rstn1),
        .bus (if1)
    );

    function automatic logic [31:0] word(input logic [15:0] a);
        return 32'h00000013 + ({18'd0, a[15:2]} << 8);
    endfunction

    function automatic exp_t mk(input logic [15:0] pc);
        return {pc, word(pc)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // SRAM models: data appears the cycle after the enabling edge.
    always @(posedge clk) if (if0.ins_e === 1'b1) if0.ins <= word(if0.ins_a);
    always @(posedge clk) if (if1.ins_e === 1'b1) if1.ins <= word(if1.ins_a);

    // Monitors: every accepted head must match the next expected entry.
    always @(negedge clk) begin
        if (if0.ifu_vld === 1'b1 && if0.ifu_rdy === 1'b1) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut0 unexpected head: got pc=%h ins=%h, required none", if0.ifu_pc, if0.ifu_ins);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0 head pc", 32'(if0.ifu_pc), 32'(e.pc));
                check("dut0 head ins", if0.ifu_ins, e.ins);
            end
        end
    end

    always @(negedge clk) begin
        if (if1.ifu_vld === 1'b1 && if1.ifu_rdy === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut1 unexpected head: got pc=%h ins=%h, required none", if1.ifu_pc, if1.ifu_ins);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 head pc", 32'(if1.ifu_pc), 32'(e.pc));
                check("dut1 head ins", if1.ifu_ins, e.ins);
            end
        end
    end

    // Wait (bounded) until the expected queue is consumed, then stop accepting.
    task automatic drain(input int d);
        int sz;
        sz = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) break;
        end
        check($sformatf("dut%0d drain remaining", d), 32'(sz), 32'd0);
        #1;
        if (d == 0) if0.ifu_rdy = 1'b0;
        else        if1.ifu_rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.ifu_rdy = 1'b0; if0.redir_e = 1'b0; if0.redir_pc = 16'h0000;
        if1.ifu_rdy = 1'b0; if1.redir_e = 1'b0; if1.redir_pc = 16'h0000;
        rstn0 = 1'b1;
        rstn1 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ins_e", 32'(if0.ins_e), 32'd0);
        check("rst ins_a", 32'(if0.ins_a), 32'h0000);
        check("rst ifu_vld", 32'(if0.ifu_vld), 32'd0);
        check("rst ifu_pc", 32'(if0.ifu_pc), 32'h0000);
        check("rst ifu_ins", if0.ifu_ins, 32'h00000000);
        check("rst dut1 ins_a", 32'(if1.ins_a), 32'h0000FFF8);
        check("rst dut1 ins_e", 32'(if1.ins_e), 32'd0);

        // Stream from reset with ifu_rdy=1: valid from cycle 2, one per cycle
        @(posedge clk); #1;
        rstn0 = 1'b0;
        if0.ifu_rdy = 1'b1;
        for (int i = 0; i < 8; i++) q0.push_back(mk(16'(4 * i)));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("first ins_e", 32'(if0.ins_e), 32'd1);
                check("first ins_a", 32'(if0.ins_a), 32'h0000);
            end
            check($sformatf("stream vld c%0d", k), 32'(if0.ifu_vld), (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) check($sformatf("stream pc c%0d", k), 32'(if0.ifu_pc), 32'(4 * (k - 2)));
        end
        drain(0);

        // Back-pressure: head pc 0x20 held, fetch stops once buffer+inflight full
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall vld", 32'(if0.ifu_vld), 32'd1);
            check("stall pc", 32'(if0.ifu_pc), 32'h0020);
            check("stall ins", if0.ifu_ins, 32'h00000813);
            check("stall ins_e", 32'(if0.ins_e), 32'd0);
        end
        @(posedge clk); #1;
        if0.ifu_rdy = 1'b1;
        for (int i = 0; i < 6; i++) q0.push_back(mk(16'(16'h0020 + 4 * i)));
        drain(0);

        // Redirect coinciding with a pop, then a second redirect to 0x0100
        @(posedge clk); #1;
        if0.ifu_rdy  = 1'b1;
        if0.redir_e  = 1'b1;
        if0.redir_pc = 16'h0202;
        @(negedge clk);
        check("redir1 vld", 32'(if0.ifu_vld), 32'd0);
        @(posedge clk); #1;
        if0.redir_pc = 16'h0100;
        @(negedge clk);
        check("redir2 vld", 32'(if0.ifu_vld), 32'd0);
        check("redir2 ins_e", 32'(if0.ins_e), 32'd0);
        @(posedge clk); #1;
        if0.redir_e = 1'b0;
        q0.push_back({16'h0100, 32'h00004013});
        q0.push_back({16'h0104, 32'h00004113});
        q0.push_back({16'h0108, 32'h00004213});
        q0.push_back({16'h010C, 32'h00004313});
        @(negedge clk);
        check("post-redir ins_e", 32'(if0.ins_e), 32'd1);
        check("post-redir ins_a", 32'(if0.ins_a), 32'h0100);
        drain(0);

        // Asynchronous reset mid-stream, between edges
        @(posedge clk); #1;
        if0.ifu_rdy = 1'b1;
        q0.push_back({16'h0110, 32'h00004413});
        @(posedge clk); #3;
        rstn0 = 1'b1;
        #1;
        check("async rst vld", 32'(if0.ifu_vld), 32'd0);
        check("async rst pc", 32'(if0.ifu_pc), 32'h0000);
        check("async rst ins", if0.ifu_ins, 32'h00000000);
        check("async rst ins_e", 32'(if0.ins_e), 32'd0);
        check("async rst ins_a", 32'(if0.ins_a), 32'h0000);
        @(posedge clk);
        @(negedge clk);
        check("held rst ins_e", 32'(if0.ins_e), 32'd0);
        check("held rst vld", 32'(if0.ifu_vld), 32'd0);
        @(posedge clk); #1;
        rstn0 = 1'b0;
        for (int i = 0; i < 4; i++) q0.push_back(mk(16'(4 * i)));
        @(negedge clk);
        check("restart ins_e", 32'(if0.ins_e), 32'd1);
        check("restart ins_a", 32'(if0.ins_a), 32'h0000);
        drain(0);

        // dut1: PC wrap from RST_PC=0xFFF8
        @(posedge clk); #1;
        rstn1 = 1'b0;
        if1.ifu_rdy = 1'b1;
        q1.push_back({16'hFFF8, 32'h003FFE13});
        q1.push_back({16'hFFFC, 32'h003FFF13});
        q1.push_back({16'h0000, 32'h00000013});
        q1.push_back({16'h0004, 32'h00000113});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("dut1 first ins_a", 32'(if1.ins_a), 32'h0000FFF8);
                check("dut1 first ins_e", 32'(if1.ins_e), 32'd1);
            end
            check($sformatf("dut1 vld c%0d", k), 32'(if1.ifu_vld), (k >= 2) ? 32'd1 : 32'd0);
        end
        drain(1);

        // dut1: redirect while two entries buffered and one in flight
        @(posedge clk); #1;
        if1.redir_e  = 1'b1;
        if1.redir_pc = 16'h0043;
        @(negedge clk);
        check("dut1 redir vld", 32'(if1.ifu_vld), 32'd0);
        check("dut1 redir ins_e", 32'(if1.ins_e), 32'd0);
        @(posedge clk); #1;
        if1.redir_e = 1'b0;
        if1.ifu_rdy = 1'b1;
        q1.push_back({16'h0040, 32'h00001013});
        q1.push_back({16'h0044, 32'h00001113});
        q1.push_back({16'h0048, 32'h00001213});
        @(negedge clk);
        check("dut1 after redir vld", 32'(if1.ifu_vld), 32'd0);
        check("dut1 after redir ins_e", 32'(if1.ins_e), 32'd1);
        check("dut1 after redir ins_a", 32'(if1.ins_a), 32'h0040);
        drain(1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
